day03_kpick_core: RTL and testbench

// - Streaming solver for the day-03 "largest K-digit subsequence" problem, with two independent pick counts.
// - Reads ASCII bytes from a ROM and splits them into lines.
// - For each line, greedily picks the largest K_A-digit and the largest K_B-digit in-order subsequence.
// - Sums both values over all lines into part1/part2.
// - Double-buffered: line i+1 loads while line i is processed. Adds line counting and an overflow flag.

---
 rtl/day03_kpick_core.sv | 191 +++++++++++++++++++
 tb/tb_day03_kpick_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/day03_kpick_core.sv
// Streaming day-03 solver: loads ASCII lines from a ROM into double-buffered digit bitmaps
// and greedily picks the largest K_A- and K_B-digit subsequences of each line.
module day03_kpick_core #(
  parameter int N_ADDR_BITS  = 16,
  parameter int MAX_LINE_LEN = 128,
  parameter int K_A          = 2,
  parameter int K_B          = 12,
  parameter int RES_W        = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rom_data,
  input  logic                   rom_valid,
  output logic [N_ADDR_BITS:0]   rom_addr,
  output logic [RES_W-1:0]       part1_result,
  output logic [RES_W-1:0]       part2_result,
  output logic [15:0]            line_count,
  output logic                   overflow,
  output logic                   done
);
  localparam int IDX_W = $clog2(MAX_LINE_LEN) + 1;
  localparam int POS_W = $clog2(MAX_LINE_LEN);
  localparam int REM_W = 5;

  typedef enum logic [2:0] {S_IDLE, S_PICK_A, S_ADD_A, S_PICK_B, S_ADD_B, S_DONE} state_t;
  state_t state;

  logic [MAX_LINE_LEN-1:0] bitmap [2][10];
  logic [IDX_W-1:0]        len_buf [2];
  logic [IDX_W-1:0]        load_idx;
  logic                    lbuf, vld_p0, hold, hold_eof, eof_seen, ready;

  logic                    pbuf;
  logic [IDX_W-1:0]        plen, scan, hi;
  logic [REM_W-1:0]        rem;
  logic [RES_W-1:0]        acc, sum_a, sum_b;

  logic       is_digit, is_term, got, at_eof, busy, end_line, adv;
  logic [3:0] digit;

  // vld_p0 marks that rom_data belongs to rom_addr-1; after a held cycle it is a prefetch and is ignored.
  always_comb begin
    digit    = rom_data[3:0];
    is_digit = (rom_data >= 8'h30) && (rom_data <= 8'h39);
    is_term  = (rom_data == 8'h0A) || (rom_data == 8'h00);
    busy     = (state != S_IDLE) || ready;
    got      = vld_p0 && rom_valid && !hold && !eof_seen;
    at_eof   = vld_p0 && !rom_valid && !hold && !eof_seen;
    end_line = 1'b0;
    adv      = 1'b0;
    if (hold) begin
      end_line = !busy;
      adv      = !busy && !hold_eof;
    end else if (got) begin
      if (is_term && load_idx != '0) begin
        end_line = !busy;
        adv      = !busy;
      end else begin
        adv = 1'b1;
      end
    end else if (at_eof) begin
      end_line = (load_idx != '0) && !busy;
    end else if (rom_addr == '0 && !eof_seen) begin
      adv = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      vld_p0   <= 1'b0;
      hold     <= 1'b0;
      hold_eof <= 1'b0;
      eof_seen <= 1'b0;
      ready    <= 1'b0;
      lbuf     <= 1'b0;
      load_idx <= '0;
      overflow <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        len_buf[b] <= '0;
        for (int d = 0; d < 10; d++) bitmap[b][d] <= '0;
      end
    end else begin
      vld_p0 <= adv;
      if (adv) rom_addr <= rom_addr + 1'b1;
      if (state == S_IDLE && ready) ready <= 1'b0;
      if (got && is_digit) begin
        if (load_idx < IDX_W'(MAX_LINE_LEN)) begin
          bitmap[lbuf][digit][load_idx[POS_W-1:0]] <= 1'b1;
          load_idx <= load_idx + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (!hold && !end_line && load_idx != '0 && ((got && is_term) || at_eof)) begin
        hold     <= 1'b1;
        hold_eof <= at_eof;
      end
      if (end_line) begin
        hold          <= 1'b0;
        len_buf[lbuf] <= load_idx;
        lbuf          <= ~lbuf;
        load_idx      <= '0;
        ready         <= 1'b1;
        for (int d = 0; d < 10; d++) bitmap[~lbuf][d] <= '0;
      end
      if ((at_eof && (load_idx == '0 || end_line)) || (hold && hold_eof && end_line))
        eof_seen <= 1'b1;
    end
  end

  logic [9:0]       hit;
  logic [POS_W-1:0] hpos [10];
  logic [3:0]       pick_d;
  logic [POS_W-1:0] pick_p;

  // Highest digit whose first occurrence falls inside [scan, plen-rem]; later digits override.
  always_comb begin
    hi     = plen - IDX_W'(rem);
    pick_d = '0;
    pick_p = '0;
    for (int d = 0; d < 10; d++) begin
      hit[d]  = 1'b0;
      hpos[d] = '0;
      for (int i = MAX_LINE_LEN - 1; i >= 0; i--) begin
        if (bitmap[pbuf][d][i] && IDX_W'(i) >= scan && IDX_W'(i) <= hi) begin
          hit[d]  = 1'b1;
          hpos[d] = POS_W'(i);
        end
      end
      if (hit[d]) begin
        pick_d = 4'(d);
        pick_p = hpos[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pbuf         <= 1'b0;
      plen         <= '0;
      scan         <= '0;
      rem          <= '0;
      acc          <= '0;
      sum_a        <= '0;
      sum_b        <= '0;
      part1_result <= '0;
      part2_result <= '0;
      line_count   <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ready) begin
            pbuf  <= ~lbuf;
            plen  <= len_buf[~lbuf];
            rem   <= REM_W'(K_A);
            scan  <= '0;
            acc   <= '0;
            state <= (len_buf[~lbuf] < IDX_W'(K_A)) ? S_ADD_A : S_PICK_A;
          end else if (eof_seen) begin
            part1_result <= sum_a;
            part2_result <= sum_b;
            done         <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_PICK_A, S_PICK_B: begin
          acc  <= acc * RES_W'(10) + RES_W'(pick_d);
          scan <= IDX_W'(pick_p) + 1'b1;
          rem  <= rem - 1'b1;
          if (rem == REM_W'(1)) state <= (state == S_PICK_A) ? S_ADD_A : S_ADD_B;
        end
        S_ADD_A: begin
          sum_a <= sum_a + acc;
          rem   <= REM_W'(K_B);
          scan  <= '0;
          acc   <= '0;
          state <= (plen < IDX_W'(K_B)) ? S_ADD_B : S_PICK_B;
        end
        S_ADD_B: begin
          sum_b <= sum_b + acc;
          if (line_count != 16'hFFFF) line_count <= line_count + 1'b1;
          state <= S_IDLE;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_day03_kpick_core.sv
// Bench for day03_kpick_core: directed and random ROM images against a line-level reference model.
module tb_day03_kpick_core;
  localparam int MAXL = 128;
  localparam int K_A  = 2;
  localparam int K_B  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_valid = 1'b0;
  logic [16:0] rom_addr;
  logic [63:0] part1_result, part2_result;
  logic [15:0] line_count;
  logic        overflow, done;

  day03_kpick_core #(.N_ADDR_BITS(16), .MAX_LINE_LEN(MAXL), .K_A(K_A), .K_B(K_B), .RES_W(64)) dut (
    .clk(clk), .rst(rst), .rom_data(rom_data), .rom_valid(rom_valid), .rom_addr(rom_addr),
    .part1_result(part1_result), .part2_result(part2_result), .line_count(line_count),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  byte unsigned mem [0:4095];
  int           rom_len = 0;
  logic [16:0]  a_q = '0;

  // Synchronous ROM: data seen at a posedge belongs to the address of the previous cycle.
  always @(negedge clk) begin
    rom_valid = (int'(a_q) < rom_len);
    rom_data  = rom_valid ? mem[int'(a_q)] : 8'h00;
    a_q       = rom_addr;
  end

  int          holds = 0;
  logic        step_bad = 1'b0;
  logic [16:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst) prev_addr = '0;
    else begin
      if (rom_addr != prev_addr && rom_addr != prev_addr + 17'd1) step_bad = 1'b1;
      if (rom_addr == prev_addr && rom_addr != '0 && int'(rom_addr) <= rom_len) holds++;
      prev_addr = rom_addr;
    end
  end

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_rom(); rom_len = 0; endtask
  task automatic put(input byte unsigned b); mem[rom_len] = b; rom_len++; endtask
  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  function automatic logic [63:0] best(input int dg[$], input int k);
    int start, n;
    logic [63:0] v;
    n = dg.size();
    v = '0;
    if (n < k) return '0;
    start = 0;
    for (int r = k; r > 0; r--) begin
      int bi;
      bi = start;
      for (int j = start; j <= n - r; j++) if (dg[j] > dg[bi]) bi = j;
      v = v * 10 + 64'(dg[bi]);
      start = bi + 1;
    end
    return v;
  endfunction

  logic [63:0] e1, e2;
  int          e_lc;
  logic        e_ov;
  task automatic model();
    int dg[$];
    e1 = '0; e2 = '0; e_lc = 0; e_ov = 1'b0;
    dg = {};
    for (int i = 0; i <= rom_len; i++) begin
      if (i == rom_len || mem[i] == 8'h0A || mem[i] == 8'h00) begin
        if (dg.size() > 0) begin
          e1 += best(dg, K_A);
          e2 += best(dg, K_B);
          e_lc++;
        end
        dg = {};
      end else if (mem[i] >= 8'h30 && mem[i] <= 8'h39) begin
        if (dg.size() < MAXL) dg.push_back(int'(mem[i]) - 48);
        else e_ov = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    holds = 0;
    step_bad = 1'b0;
    check({name, "_rst_p1"}, part1_result, 0);
    check({name, "_rst_p2"}, part2_result, 0);
    check({name, "_rst_lc"}, 64'(line_count), 0);
    check({name, "_rst_addr"}, 64'(rom_addr), 0);
    check({name, "_rst_flags"}, {62'd0, overflow, done}, 0);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, 64'(done), 1);
  endtask

  task automatic check_vs(input string name, input logic [63:0] p1, input logic [63:0] p2,
                          input int lc, input logic ov);
    check({name, "_p1"}, part1_result, p1);
    check({name, "_p2"}, part2_result, p2);
    check({name, "_lc"}, 64'(line_count), 64'(lc));
    check({name, "_ov"}, 64'(overflow), 64'(ov));
  endtask

  task automatic load_aoc();
    clear_rom();
    put_str("987654321111111\n811111111111119\n234234234234278\n818181911112111\n");
  endtask

  initial begin
    load_aoc();
    do_reset("aoc");
    wait_done("aoc");
    check_vs("aoc", 64'd357, 64'd3121910778619, 4, 1'b0);
    repeat (5) @(negedge clk);
    check("aoc_hold_p2", part2_result, 64'd3121910778619);

    clear_rom();
    put_str("987654321111111");
    do_reset("flush");
    wait_done("flush");
    check_vs("flush", 64'd98, 64'd987654321111, 1, 1'b0);

    clear_rom();
    put_str("\n\n12\n");
    do_reset("short");
    wait_done("short");
    check_vs("short", 64'd12, 64'd0, 1, 1'b0);

    clear_rom();
    for (int i = 0; i < 130; i++) put(8'h31);
    put(8'h0A);
    do_reset("ovf");
    wait_done("ovf");
    check_vs("ovf", 64'd11, 64'd111111111111, 1, 1'b1);

    clear_rom();
    for (int l = 0; l < 8; l++) begin
      for (int j = 0; j < 12; j++) put(8'(8'h30 + $urandom_range(0, 9)));
      put(8'h0A);
    end
    model();
    do_reset("b2b");
    wait_done("b2b");
    check_vs("b2b", e1, e2, e_lc, e_ov);
    check("b2b_stalled", 64'(holds > 0), 1);
    check("b2b_addr_step", 64'(step_bad), 0);

    for (int t = 0; t < 4; t++) begin
      int nl;
      clear_rom();
      nl = $urandom_range(3, 12);
      for (int l = 0; l < nl; l++) begin
        int n;
        n = $urandom_range(0, 25);
        for (int j = 0; j < n; j++) begin
          int r;
          r = $urandom_range(0, 19);
          if (r == 0) put(8'h78);
          else if (r == 1) put(8'h20);
          else put(8'(8'h30 + $urandom_range(0, 9)));
        end
        if (l != nl - 1 || $urandom_range(0, 1) == 1) put(($urandom_range(0, 3) == 0) ? 8'h00 : 8'h0A);
      end
      model();
      do_reset("rand");
      wait_done("rand");
      check_vs("rand", e1, e2, e_lc, e_ov);
      check("rand_addr_step", 64'(step_bad), 0);
    end

    load_aoc();
    do_reset("midrst");
    repeat (27) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_p1", part1_result, 0);
    check("midrst_p2", part2_result, 0);
    check("midrst_lc", 64'(line_count), 0);
    check("midrst_addr", 64'(rom_addr), 0);
    check("midrst_flags", {62'd0, overflow, done}, 0);
    rst = 1'b0;
    wait_done("midrst");
    check_vs("midrst", 64'd357, 64'd3121910778619, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
